core_sequencer: RTL and testbench

Multi-cycle fetch/execute/memory sequencer for the RV32E core, replacing single-cycle lock-step operation with handshaked instruction and data buses that tolerate wait states. It owns the PC and instruction register, drives the existing combinational datapath (decode, ALU, branch compare, load/store generators), and emits one commit strobe per retired instruction. It adds a multi-channel interrupt input, optional vectored trap entry and a bus-timeout watchdog.

---
 rtl/core_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_core_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/exec/mem/wb/trap control for the RV32E core.
// Owns PC/IR, drives handshaked ibus/dbus, raises commit and trap strobes.
module core_sequencer #(
    parameter logic [31:0] RESET       = 32'h0000_0000,
    parameter logic [31:0] VECTOR      = 32'h0000_0000,
    parameter bit          VECTORED    = 1'b0,
    parameter int          NUM_IRQ     = 4,
    parameter int          BUS_TIMEOUT = 255
) (
    input  logic               I_clk,
    input  logic               I_rst,
    output logic               O_ibus_req,
    output logic [31:0]        O_ibus_addr,
    input  logic               I_ibus_ack,
    input  logic [31:0]        I_ibus_data,
    output logic               O_dbus_req,
    output logic               O_dbus_we,
    output logic [31:0]        O_dbus_addr,
    output logic [31:0]        O_dbus_wdata,
    output logic [3:0]         O_dbus_be,
    input  logic               I_dbus_ack,
    input  logic [31:0]        I_dbus_rdata,
    output logic [31:0]        O_pc,
    output logic [31:0]        O_ir,
    input  logic [31:0]        I_next_pc,
    input  logic               I_is_load,
    input  logic               I_is_store,
    input  logic [31:0]        I_mem_addr,
    input  logic [31:0]        I_store_data,
    input  logic [3:0]         I_store_be,
    input  logic               I_illegal,
    input  logic               I_ecall,
    input  logic               I_ebreak,
    input  logic               I_mret,
    input  logic [31:0]        I_mepc,
    input  logic [NUM_IRQ-1:0] I_irq,
    input  logic [NUM_IRQ-1:0] I_irq_mask,
    input  logic               I_irq_enable,
    output logic [31:0]        O_load_data,
    output logic               O_commit,
    output logic               O_trap,
    output logic [31:0]        O_trap_cause,
    output logic [31:0]        O_trap_epc
);

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] ir;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_we;
    logic [31:0] m_npc;
    logic [31:0] load_data;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [15:0] cnt;

    logic        commit;
    logic        ir_load;
    logic        mem_latch;
    logic        load_latch;
    logic        trap_set;
    logic [31:0] cause_next;
    logic [31:0] epc_next;
    logic        boundary;
    logic [31:0] bpc;
    logic        to_hit;

    logic [NUM_IRQ-1:0] irq_pend;
    logic [3:0]         irq_idx;
    logic               irq_take;
    logic [31:0]        irq_cause;

    // Lowest-numbered enabled pending channel wins.
    always_comb begin
        irq_pend = I_irq & I_irq_mask;
        irq_idx  = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) irq_idx = 4'(i);
        end
        irq_take  = I_irq_enable && (|irq_pend);
        irq_cause = {1'b1, 26'd0, 1'b1, irq_idx};
    end

    assign to_hit = (BUS_TIMEOUT != 0) && (cnt == TO_LAST);

    // Next-state, next-PC and strobe decode for the sequencer.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        commit     = 1'b0;
        ir_load    = 1'b0;
        mem_latch  = 1'b0;
        load_latch = 1'b0;
        trap_set   = 1'b0;
        cause_next = cause;
        epc_next   = epc;
        boundary   = 1'b0;
        bpc        = pc;
        unique case (state)
            FETCH: begin
                if (I_ibus_ack) begin
                    ir_load    = 1'b1;
                    state_next = EXEC;
                end else if (to_hit) begin
                    trap_set   = 1'b1;
                    cause_next = 32'd1;
                    epc_next   = pc;
                    state_next = TRAP;
                end
            end
            EXEC: begin
                if (I_illegal || I_ebreak || I_ecall) begin
                    trap_set   = 1'b1;
                    epc_next   = pc;
                    state_next = TRAP;
                    if (I_illegal)     cause_next = 32'd2;
                    else if (I_ebreak) cause_next = 32'd3;
                    else               cause_next = 32'd11;
                end else if (I_mret) begin
                    commit   = 1'b1;
                    boundary = 1'b1;
                    bpc      = I_mepc;
                end else if (I_is_load || I_is_store) begin
                    mem_latch  = 1'b1;
                    state_next = MEM;
                end else begin
                    commit   = 1'b1;
                    boundary = 1'b1;
                    bpc      = I_next_pc;
                end
            end
            MEM: begin
                if (I_dbus_ack) begin
                    if (m_we) begin
                        commit   = 1'b1;
                        boundary = 1'b1;
                        bpc      = m_npc;
                    end else begin
                        load_latch = 1'b1;
                        state_next = WB;
                    end
                end else if (to_hit) begin
                    trap_set   = 1'b1;
                    cause_next = m_we ? 32'd7 : 32'd5;
                    epc_next   = pc;
                    state_next = TRAP;
                end
            end
            WB: begin
                commit   = 1'b1;
                boundary = 1'b1;
                bpc      = m_npc;
            end
            TRAP: begin
                state_next = FETCH;
                if (VECTORED && cause[31])
                    pc_next = VECTOR + {25'd0, cause[4:0], 2'b00};
                else
                    pc_next = VECTOR;
            end
            default: state_next = FETCH;
        endcase
        if (boundary) begin
            pc_next = bpc;
            if (irq_take) begin
                trap_set   = 1'b1;
                cause_next = irq_cause;
                epc_next   = bpc;
                state_next = TRAP;
            end else begin
                state_next = FETCH;
            end
        end
    end

    // State register.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state <= FETCH;
        else       state <= state_next;
    end

    // PC, IR, latched memory operands, load data, trap info and wait counter.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pc        <= RESET;
            ir        <= 32'd0;
            m_addr    <= 32'd0;
            m_wdata   <= 32'd0;
            m_be      <= 4'd0;
            m_we      <= 1'b0;
            m_npc     <= 32'd0;
            load_data <= 32'd0;
            cause     <= 32'd0;
            epc       <= 32'd0;
            cnt       <= 16'd0;
        end else begin
            pc <= pc_next;
            if (ir_load) ir <= I_ibus_data;
            if (mem_latch) begin
                m_addr  <= I_mem_addr;
                m_wdata <= I_store_data;
                m_be    <= I_store_be;
                m_we    <= I_is_store;
                m_npc   <= I_next_pc;
            end
            if (load_latch) load_data <= I_dbus_rdata;
            if (trap_set) begin
                cause <= cause_next;
                epc   <= epc_next;
            end
            // Only FETCH and MEM self-loop, so a state change restarts the count.
            if (state_next != state)  cnt <= 16'd0;
            else if (BUS_TIMEOUT != 0) cnt <= cnt + 16'd1;
        end
    end

    assign O_ibus_req   = (state == FETCH) && !I_rst;
    assign O_ibus_addr  = pc;
    assign O_dbus_req   = (state == MEM);
    assign O_dbus_we    = m_we;
    assign O_dbus_addr  = m_addr;
    assign O_dbus_wdata = m_wdata;
    assign O_dbus_be    = m_be;
    assign O_pc         = pc;
    assign O_ir         = ir;
    assign O_load_data  = load_data;
    assign O_commit     = commit;
    assign O_trap       = (state == TRAP);
    assign O_trap_cause = cause;
    assign O_trap_epc   = epc;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scoreboard bench for core_sequencer.
// Stimulus queues expected bus/commit/trap events; a monitor pops and compares.
module tb_core_sequencer;

    localparam int NIRQ = 4;

    localparam logic [1:0] EV_FETCH  = 2'd0;
    localparam logic [1:0] EV_MEM    = 2'd1;
    localparam logic [1:0] EV_COMMIT = 2'd2;
    localparam logic [1:0] EV_TRAP   = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack;
    logic [31:0] ibus_addr, ibus_data, dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0] dbus_be, store_be;
    logic [31:0] pc, ir, next_pc, mem_addr, store_data, mepc;
    logic is_load, is_store, illegal, ecall, ebreak, mret;
    logic [NIRQ-1:0] irq, irq_mask;
    logic irq_enable;
    logic [31:0] load_data, trap_cause, trap_epc;
    logic commit, trap;

    always #5 clk = ~clk;

    core_sequencer #(
        .RESET(32'h0000_0100),
        .VECTOR(32'h0000_1000),
        .VECTORED(1'b1),
        .NUM_IRQ(NIRQ),
        .BUS_TIMEOUT(4)
    ) dut (
        .I_clk(clk), .I_rst(rst),
        .O_ibus_req(ibus_req), .O_ibus_addr(ibus_addr),
        .I_ibus_ack(ibus_ack), .I_ibus_data(ibus_data),
        .O_dbus_req(dbus_req), .O_dbus_we(dbus_we),
        .O_dbus_addr(dbus_addr), .O_dbus_wdata(dbus_wdata),
        .O_dbus_be(dbus_be),
        .I_dbus_ack(dbus_ack), .I_dbus_rdata(dbus_rdata),
        .O_pc(pc), .O_ir(ir), .I_next_pc(next_pc),
        .I_is_load(is_load), .I_is_store(is_store),
        .I_mem_addr(mem_addr), .I_store_data(store_data),
        .I_store_be(store_be),
        .I_illegal(illegal), .I_ecall(ecall), .I_ebreak(ebreak),
        .I_mret(mret), .I_mepc(mepc),
        .I_irq(irq), .I_irq_mask(irq_mask), .I_irq_enable(irq_enable),
        .O_load_data(load_data), .O_commit(commit),
        .O_trap(trap), .O_trap_cause(trap_cause), .O_trap_epc(trap_epc)
    );

    typedef struct {
        logic [1:0]  kind;
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  be;
        logic        we;
        bit          ld;
        int          lat;
    } ev_t;

    ev_t q[$];
    int passed = 0;
    int total = 0;
    int cyc = 0;
    int fcyc = 0;
    bit mon_on = 1'b1;

    int iwait = 0;
    int dwait = 0;
    int icnt = 0;
    int dcnt = 0;
    logic [31:0] idata = 32'd0;
    logic [31:0] rdata = 32'd0;
    bit dstray = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic take(input logic [1:0] k);
        ev_t e;
        if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
        end else begin
            e = q.pop_front();
            chk({e.tag, "_kind"}, 32'(k), 32'(e.kind));
            if (k == e.kind) begin
                case (k)
                    EV_FETCH: chk({e.tag, "_fetch_addr"}, ibus_addr, e.a);
                    EV_MEM: begin
                        chk({e.tag, "_dbus_addr"}, dbus_addr, e.a);
                        chk({e.tag, "_dbus_wdata"}, dbus_wdata, e.b);
                        chk({e.tag, "_dbus_be_we"}, {27'd0, dbus_be, dbus_we}, {27'd0, e.be, e.we});
                    end
                    EV_COMMIT: begin
                        chk({e.tag, "_commit_pc"}, pc, e.a);
                        chk({e.tag, "_commit_ir"}, ir, e.b);
                        if (e.ld) chk({e.tag, "_load_data"}, load_data, e.c);
                    end
                    default: begin
                        chk({e.tag, "_trap_cause"}, trap_cause, e.a);
                        chk({e.tag, "_trap_epc"}, trap_epc, e.b);
                    end
                endcase
                if (e.lat != 0) chk({e.tag, "_latency"}, 32'(cyc - fcyc + 1), 32'(e.lat));
            end
        end
    endtask

    // Bus responders: ack after a programmed number of wait cycles (-1 = never).
    initial begin
        ibus_ack = 1'b0;
        dbus_ack = 1'b0;
        ibus_data = 32'd0;
        dbus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (ibus_req) begin
                if (icnt == iwait) begin ibus_ack = 1'b1; icnt = 0; end
                else begin ibus_ack = 1'b0; icnt++; end
            end else begin
                ibus_ack = 1'b0;
                icnt = 0;
            end
            ibus_data = idata;
            if (dbus_req) begin
                if (dcnt == dwait) begin dbus_ack = 1'b1; dcnt = 0; end
                else begin dbus_ack = 1'b0; dcnt++; end
            end else begin
                dbus_ack = dstray;
                dcnt = 0;
            end
            dbus_rdata = rdata;
        end
    end

    // Monitor: one observation per cycle, after responders have settled.
    initial begin
        logic pi, pd;
        pi = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                pi = 1'b0;
                pd = 1'b0;
            end else if (mon_on) begin
                if (ibus_req && !pi) begin fcyc = cyc; take(EV_FETCH); end
                if (dbus_req && !pd) take(EV_MEM);
                if (commit) take(EV_COMMIT);
                if (trap) take(EV_TRAP);
                pi = ibus_req;
                pd = dbus_req;
            end
        end
    end

    task automatic exp_fetch(input string t, input logic [31:0] a);
        ev_t e;
        e = '{kind: EV_FETCH, tag: t, a: a, b: 0, c: 0, be: 0, we: 0, ld: 0, lat: 0};
        q.push_back(e);
    endtask

    task automatic exp_mem(input string t, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic we);
        ev_t e;
        e = '{kind: EV_MEM, tag: t, a: a, b: d, c: 0, be: be, we: we, ld: 0, lat: 0};
        q.push_back(e);
    endtask

    task automatic exp_commit(input string t, input logic [31:0] a, input logic [31:0] w,
                              input bit ld, input logic [31:0] d, input int lat);
        ev_t e;
        e = '{kind: EV_COMMIT, tag: t, a: a, b: w, c: d, be: 0, we: 0, ld: ld, lat: lat};
        q.push_back(e);
    endtask

    task automatic exp_trap(input string t, input logic [31:0] c, input logic [31:0] epc,
                            input int lat);
        ev_t e;
        e = '{kind: EV_TRAP, tag: t, a: c, b: epc, c: 0, be: 0, we: 0, ld: 0, lat: lat};
        q.push_back(e);
    endtask

    task automatic clear_dp();
        is_load = 0; is_store = 0; illegal = 0; ecall = 0; ebreak = 0; mret = 0;
        mem_addr = 0; store_data = 0; store_be = 4'hf; mepc = 0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL event_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic finish_instr();
        wait_empty();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        clear_dp();
        next_pc = 0;
        irq = 0; irq_mask = 0; irq_enable = 0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_pc", pc, 32'h100);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ibus_req", 32'(ibus_req), 32'h0);
        chk("rst_dbus_req", 32'(dbus_req), 32'h0);
        chk("rst_strobes", {30'd0, commit, trap}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_cause_epc", trap_cause | trap_epc, 32'h0);

        // ADDI at reset PC with 3 fetch wait cycles
        idata = 32'h0050_0093; iwait = 3; next_pc = 32'h104;
        exp_fetch("addi", 32'h100);
        exp_commit("addi", 32'h100, idata, 0, 0, 5);
        @(posedge clk); #1; rst = 0;
        finish_instr();

        // jump to 0x200
        idata = 32'h0fc0_006f; iwait = 0; next_pc = 32'h200;
        exp_fetch("jal", 32'h104);
        exp_commit("jal", 32'h104, idata, 0, 0, 2);
        finish_instr();

        // load with 2 data wait cycles
        idata = 32'h0000_a083; is_load = 1; mem_addr = 32'h3000_0010;
        next_pc = 32'h204; dwait = 2; rdata = 32'hDEAD_BEEF;
        exp_fetch("lw", 32'h200);
        exp_mem("lw", 32'h3000_0010, 32'h0, 4'hf, 1'b0);
        exp_commit("lw", 32'h200, idata, 1, 32'hDEAD_BEEF, 6);
        finish_instr();

        // zero-wait store
        clear_dp();
        idata = 32'h0011_2023; is_store = 1; mem_addr = 32'h3000_0020;
        store_data = 32'h1234_5678; store_be = 4'b1100; next_pc = 32'h208; dwait = 0;
        exp_fetch("sw", 32'h204);
        exp_mem("sw", 32'h3000_0020, 32'h1234_5678, 4'b1100, 1'b1);
        exp_commit("sw", 32'h204, idata, 0, 0, 3);
        finish_instr();

        // mret to 0x40
        clear_dp();
        idata = 32'h3020_0073; mret = 1; mepc = 32'h40; next_pc = 32'h20c;
        exp_fetch("mret", 32'h208);
        exp_commit("mret", 32'h208, idata, 0, 0, 2);
        finish_instr();

        // illegal outranks ecall
        clear_dp();
        idata = 32'hffff_ffff; illegal = 1; ecall = 1;
        exp_fetch("illegal", 32'h40);
        exp_trap("illegal", 32'd2, 32'h40, 3);
        finish_instr();

        // ebreak outranks ecall
        clear_dp();
        idata = 32'h0010_0073; ebreak = 1; ecall = 1;
        exp_fetch("ebreak", 32'h1000);
        exp_trap("ebreak", 32'd3, 32'h1000, 3);
        finish_instr();

        clear_dp();
        idata = 32'h0000_0073; ecall = 1;
        exp_fetch("ecall", 32'h1000);
        exp_trap("ecall", 32'd11, 32'h1000, 3);
        finish_instr();

        // interrupts 2 and 3 enabled and pending, 1 masked: channel 2 taken
        clear_dp();
        idata = 32'h0050_0093; next_pc = 32'h1004;
        irq = 4'b1110; irq_mask = 4'b1100; irq_enable = 1;
        exp_fetch("irq", 32'h1000);
        exp_commit("irq", 32'h1000, idata, 0, 0, 2);
        exp_trap("irq", 32'h8000_0012, 32'h1004, 3);
        finish_instr();

        // global enable off: no trap
        irq_enable = 0; next_pc = 32'h104c;
        exp_fetch("irq_off", 32'h1048);
        exp_commit("irq_off", 32'h1048, idata, 0, 0, 2);
        finish_instr();

        // store never acked: fault on the 4th wait cycle
        irq = 0;
        idata = 32'h0011_2023; is_store = 1; mem_addr = 32'h3000_0030;
        store_data = 32'hCAFE_F00D; store_be = 4'b0011; next_pc = 32'h1050; dwait = -1;
        exp_fetch("st_to", 32'h104c);
        exp_mem("st_to", 32'h3000_0030, 32'hCAFE_F00D, 4'b0011, 1'b1);
        exp_trap("st_to", 32'd7, 32'h104c, 7);
        finish_instr();

        // ack on the timeout cycle wins
        mem_addr = 32'h3000_0034; next_pc = 32'h1004; dwait = 3;
        exp_fetch("st_late", 32'h1000);
        exp_mem("st_late", 32'h3000_0034, 32'hCAFE_F00D, 4'b0011, 1'b1);
        exp_commit("st_late", 32'h1000, idata, 0, 0, 6);
        finish_instr();

        // load never acked
        clear_dp();
        idata = 32'h0000_a083; is_load = 1; mem_addr = 32'h3000_0038;
        next_pc = 32'h1008; dwait = -1;
        exp_fetch("ld_to", 32'h1004);
        exp_mem("ld_to", 32'h3000_0038, 32'h0, 4'hf, 1'b0);
        exp_trap("ld_to", 32'd5, 32'h1004, 7);
        finish_instr();

        // fetch never acked
        clear_dp();
        iwait = -1;
        exp_fetch("if_to", 32'h1000);
        exp_trap("if_to", 32'd1, 32'h1000, 5);
        finish_instr();
        iwait = 0;

        // reset while a load waits in MEM
        idata = 32'h0000_a083; is_load = 1; mem_addr = 32'h3000_0040;
        next_pc = 32'h1004; dwait = -1;
        exp_fetch("rst_mem", 32'h1000);
        exp_mem("rst_mem", 32'h3000_0040, 32'h0, 4'hf, 1'b0);
        wait_empty();
        rst = 1;
        #1;
        chk("rst_mem_dbus_req", 32'(dbus_req), 32'h0);
        chk("rst_mem_pc", pc, 32'h100);
        chk("rst_mem_ir", ir, 32'h0);
        @(posedge clk); #1;
        clear_dp();
        idata = 32'h0050_0093; next_pc = 32'h104; rdata = 32'hBADB_AD00; dstray = 1;
        exp_fetch("after_rst", 32'h100);
        exp_commit("after_rst", 32'h100, idata, 0, 0, 2);
        rst = 0;
        wait_empty();
        mon_on = 0;
        chk("late_ack_ignored", load_data, 32'h0);
        dstray = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
